// File: rtl/alu_share_arbiter.sv
// Purpose: round-robin share of one ALU among NUM_REQ requesters, returning result+flags with requester id.
// Latency: accept at t -> rsp_valid from t+2; at most one operation in flight, next accept at t+3 earliest.
// Backpressure: rsp_ready low holds the response and blocks all new accepts (req_ready stays 0).
module alu_share_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 7,
    parameter int FUNCT3_LENGTH = 3,
    parameter int FUNCT7_LENGTH = 7,
    parameter int NUM_REQ       = 2
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_rs1,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_rs2,
    input  logic [NUM_REQ*OPCODE_LENGTH-1:0]   req_opcode,
    input  logic [NUM_REQ*FUNCT3_LENGTH-1:0]   req_funct3,
    input  logic [NUM_REQ*FUNCT7_LENGTH-1:0]   req_funct7,
    input  logic [NUM_REQ*12-1:0]              req_immI,
    input  logic [NUM_REQ*20-1:0]              req_immU,
    output logic [DATA_WIDTH-1:0]              alu_rs1,
    output logic [DATA_WIDTH-1:0]              alu_rs2,
    output logic [OPCODE_LENGTH-1:0]           alu_Opcode,
    output logic [FUNCT3_LENGTH-1:0]           alu_Funct3,
    output logic [FUNCT7_LENGTH-1:0]           alu_Funct7,
    output logic [11:0]                        alu_immI,
    output logic [19:0]                        alu_immU,
    input  logic [DATA_WIDTH-1:0]              alu_rd,
    input  logic                               alu_Con_BLT,
    input  logic                               alu_Con_BGT,
    input  logic                               alu_zero,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]         rsp_id,
    output logic [DATA_WIDTH-1:0]              rsp_rd,
    output logic                               rsp_blt,
    output logic                               rsp_bgt,
    output logic                               rsp_zero,
    output logic                               busy
);

    localparam int ID_W = $clog2(NUM_REQ);
    // One extra bit so rr_ptr + offset never overflows before the modulo fold.
    localparam int SW   = ID_W + 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [ID_W-1:0]            rr_ptr;
    logic [ID_W-1:0]            ptr_nxt;
    logic                       grant_vld;
    logic [ID_W-1:0]            grant_idx;
    logic [SW-1:0]              scan;
    logic [ID_W-1:0]            cand;
    logic                       accept;

    logic [DATA_WIDTH-1:0]      rs1_a    [NUM_REQ];
    logic [DATA_WIDTH-1:0]      rs2_a    [NUM_REQ];
    logic [OPCODE_LENGTH-1:0]   opcode_a [NUM_REQ];
    logic [FUNCT3_LENGTH-1:0]   funct3_a [NUM_REQ];
    logic [FUNCT7_LENGTH-1:0]   funct7_a [NUM_REQ];
    logic [11:0]                immi_a   [NUM_REQ];
    logic [19:0]                immu_a   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign rs1_a[i]    = req_rs1[i*DATA_WIDTH +: DATA_WIDTH];
        assign rs2_a[i]    = req_rs2[i*DATA_WIDTH +: DATA_WIDTH];
        assign opcode_a[i] = req_opcode[i*OPCODE_LENGTH +: OPCODE_LENGTH];
        assign funct3_a[i] = req_funct3[i*FUNCT3_LENGTH +: FUNCT3_LENGTH];
        assign funct7_a[i] = req_funct7[i*FUNCT7_LENGTH +: FUNCT7_LENGTH];
        assign immi_a[i]   = req_immI[i*12 +: 12];
        assign immu_a[i]   = req_immU[i*20 +: 20];
    end

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        scan      = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + SW'(k);
            if (scan >= SW'(NUM_REQ)) begin
                scan = scan - SW'(NUM_REQ);
            end
            cand = scan[ID_W-1:0];
            if (!grant_vld && req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign ptr_nxt = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Next state plus req_ready/busy; ready is only offered from IDLE and never while in reset.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_vld && reset_n) begin
                    req_ready[grant_idx] = 1'b1;
                    state_nxt            = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = |req_ready;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture on accept, result capture after the EXEC cycle, response release on consume.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr     <= '0;
            alu_rs1    <= '0;
            alu_rs2    <= '0;
            alu_Opcode <= '0;
            alu_Funct3 <= '0;
            alu_Funct7 <= '0;
            alu_immI   <= '0;
            alu_immU   <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_rd     <= '0;
            rsp_blt    <= 1'b0;
            rsp_bgt    <= 1'b0;
            rsp_zero   <= 1'b0;
        end else begin
            if (accept) begin
                alu_rs1    <= rs1_a[grant_idx];
                alu_rs2    <= rs2_a[grant_idx];
                alu_Opcode <= opcode_a[grant_idx];
                alu_Funct3 <= funct3_a[grant_idx];
                alu_Funct7 <= funct7_a[grant_idx];
                alu_immI   <= immi_a[grant_idx];
                alu_immU   <= immu_a[grant_idx];
                rsp_id     <= grant_idx;
                rr_ptr     <= ptr_nxt;
            end
            if (state == EXEC) begin
                rsp_rd    <= alu_rd;
                rsp_blt   <= alu_Con_BLT;
                rsp_bgt   <= alu_Con_BGT;
                rsp_zero  <= alu_zero;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Purpose: self-checking bench for alu_share_arbiter (2-requester and 3-requester instances).
// Latency: expectations derived from accept->response of 2 cycles and 3-cycle minimum turnaround.
// Backpressure: rsp_ready is held low and randomised to exercise response stalls.
module tb_alu_share_arbiter;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [11:0] immI;
        logic [19:0] immU;
    } op_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int passed = 0;

    // Two-requester instance
    logic [1:0]  req_valid = '0, req_ready;
    logic [63:0] req_rs1 = '0, req_rs2 = '0;
    logic [13:0] req_opcode = '0, req_funct7 = '0;
    logic [5:0]  req_funct3 = '0;
    logic [23:0] req_immI = '0;
    logic [39:0] req_immU = '0;
    logic [31:0] alu_rs1, alu_rs2, alu_rd, rsp_rd;
    logic [6:0]  alu_Opcode, alu_Funct7;
    logic [2:0]  alu_Funct3;
    logic [11:0] alu_immI;
    logic [19:0] alu_immU;
    logic        alu_Con_BLT, alu_Con_BGT, alu_zero;
    logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_blt, rsp_bgt, rsp_zero, busy;

    // Three-requester instance
    logic [2:0]  req_valid3 = '0, req_ready3;
    logic [95:0] req_rs1_3 = '0, req_rs2_3 = '0;
    logic [31:0] alu_rs1_3, alu_rs2_3, alu_rd3, rsp_rd3;
    logic [6:0]  alu_Opcode3, alu_Funct7_3;
    logic [2:0]  alu_Funct3_3;
    logic [11:0] alu_immI3;
    logic [19:0] alu_immU3;
    logic        rsp_valid3, rsp_ready3 = 1'b1, rsp_blt3, rsp_bgt3, rsp_zero3, busy3;
    logic [1:0]  rsp_id3;

    alu_share_arbiter #(.NUM_REQ(2)) u_dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_opcode(req_opcode),
        .req_funct3(req_funct3), .req_funct7(req_funct7),
        .req_immI(req_immI), .req_immU(req_immU),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_Opcode(alu_Opcode),
        .alu_Funct3(alu_Funct3), .alu_Funct7(alu_Funct7),
        .alu_immI(alu_immI), .alu_immU(alu_immU),
        .alu_rd(alu_rd), .alu_Con_BLT(alu_Con_BLT), .alu_Con_BGT(alu_Con_BGT), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_rd(rsp_rd),
        .rsp_blt(rsp_blt), .rsp_bgt(rsp_bgt), .rsp_zero(rsp_zero), .busy(busy)
    );

    alu_share_arbiter #(.NUM_REQ(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_rs1(req_rs1_3), .req_rs2(req_rs2_3), .req_opcode(21'd0),
        .req_funct3(9'd0), .req_funct7(21'd0),
        .req_immI(36'd0), .req_immU(60'd0),
        .alu_rs1(alu_rs1_3), .alu_rs2(alu_rs2_3), .alu_Opcode(alu_Opcode3),
        .alu_Funct3(alu_Funct3_3), .alu_Funct7(alu_Funct7_3),
        .alu_immI(alu_immI3), .alu_immU(alu_immU3),
        .alu_rd(alu_rd3), .alu_Con_BLT(1'b0), .alu_Con_BGT(1'b0), .alu_zero(1'b0),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3), .rsp_rd(rsp_rd3),
        .rsp_blt(rsp_blt3), .rsp_bgt(rsp_bgt3), .rsp_zero(rsp_zero3), .busy(busy3)
    );

    // Behavioural ALU: {blt, bgt, zero, rd}. Unknown opcodes hash every field so mis-routed fields show up.
    function automatic logic [34:0] alu_fn(input op_t o);
        logic [31:0] rd;
        case (o.opc)
            7'b0110011: begin
                case (o.f3)
                    3'b000:  rd = (o.f7 == 7'b0100000) ? o.rs1 - o.rs2 : o.rs1 + o.rs2;
                    3'b100:  rd = o.rs1 ^ o.rs2;
                    3'b110:  rd = o.rs1 | o.rs2;
                    3'b111:  rd = o.rs1 & o.rs2;
                    default: rd = o.rs1 ^ o.rs2 ^ {25'd0, o.f7};
                endcase
            end
            7'b0010011: rd = o.rs1 + {{20{o.immI[11]}}, o.immI};
            7'b0110111: rd = {o.immU, 12'd0};
            default:    rd = o.rs1 ^ {o.rs2[15:0], o.rs2[31:16]} ^ {o.immU, o.immI} ^ {o.opc, o.f3, o.f7, 15'd0};
        endcase
        return {($signed(o.rs1) < $signed(o.rs2)), ($signed(o.rs1) > $signed(o.rs2)), (rd == 32'd0), rd};
    endfunction

    op_t         alu_view;
    logic [34:0] alu_res;
    assign alu_view = {alu_rs1, alu_rs2, alu_Opcode, alu_Funct3, alu_Funct7, alu_immI, alu_immU};
    assign alu_res  = alu_fn(alu_view);
    assign alu_rd      = alu_res[31:0];
    assign alu_zero    = alu_res[32];
    assign alu_Con_BGT = alu_res[33];
    assign alu_Con_BLT = alu_res[34];
    assign alu_rd3     = alu_rs1_3 + alu_rs2_3;

    function automatic op_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] a, input logic [31:0] b);
        op_t o;
        o = '0;
        o.opc = opc; o.f3 = f3; o.f7 = f7; o.rs1 = a; o.rs2 = b;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.rs1 = $urandom;
        o.rs2 = ($urandom_range(0, 3) == 0) ? o.rs1 : $urandom;
        case ($urandom_range(0, 3))
            0:       o.opc = 7'b0110011;
            1:       o.opc = 7'b0010011;
            2:       o.opc = 7'b0110111;
            default: o.opc = 7'($urandom);
        endcase
        o.f3   = 3'($urandom_range(0, 7));
        o.f7   = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'($urandom_range(0, 1));
        o.immI = 12'($urandom);
        o.immU = 20'($urandom);
        return o;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int i, input op_t o);
        req_rs1[i*32 +: 32]   = o.rs1;
        req_rs2[i*32 +: 32]   = o.rs2;
        req_opcode[i*7 +: 7]  = o.opc;
        req_funct3[i*3 +: 3]  = o.f3;
        req_funct7[i*7 +: 7]  = o.f7;
        req_immI[i*12 +: 12]  = o.immI;
        req_immU[i*20 +: 20]  = o.immU;
        req_valid[i]          = 1'b1;
    endtask

    task automatic do_reset();
        req_valid  = '0;
        req_valid3 = '0;
        rsp_ready  = 1'b1;
        rsp_ready3 = 1'b1;
        reset_n    = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        #1;
        total++;
        if ({busy, rsp_valid, req_ready} !== 4'b0000)
            $display("FAIL reset_ctrl: busy/rsp_valid/req_ready=%b expected 0000", {busy, rsp_valid, req_ready});
        else passed++;
        total++;
        if (alu_view !== '0) $display("FAIL reset_alu: alu regs=%h expected 0", alu_view);
        else passed++;
        total++;
        if ({rsp_id, rsp_rd, rsp_blt, rsp_bgt, rsp_zero} !== '0)
            $display("FAIL reset_rsp: rsp fields=%h expected 0", {rsp_id, rsp_rd, rsp_blt, rsp_bgt, rsp_zero});
        else passed++;
        do_reset();
    endtask

    task automatic test_single_op();
        do_reset();
        drive(0, mk(7'b0110011, 3'b000, 7'b0000000, 32'd5, 32'd10));
        #1;
        total++;
        if (req_ready !== 2'b01) $display("FAIL single_grant: req_ready=%b expected 01", req_ready);
        else passed++;
        tick();
        req_valid[0] = 1'b0;
        total++;
        if ({busy, rsp_valid, req_ready} !== 4'b1000)
            $display("FAIL single_exec: busy/rsp_valid/req_ready=%b expected 1000", {busy, rsp_valid, req_ready});
        else passed++;
        total++;
        if ({alu_rs1, alu_rs2} !== {32'd5, 32'd10})
            $display("FAIL single_operands: alu_rs1=%0d alu_rs2=%0d expected 5 10", alu_rs1, alu_rs2);
        else passed++;
        tick();
        total++;
        if ({rsp_valid, rsp_id, rsp_rd, rsp_zero} !== {1'b1, 1'b0, 32'd15, 1'b0})
            $display("FAIL single_rsp: valid=%b id=%0d rd=%0d zero=%b expected 1 0 15 0", rsp_valid, rsp_id, rsp_rd, rsp_zero);
        else passed++;
        tick();
        total++;
        if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_done: rsp_valid/busy=%b expected 00", {rsp_valid, busy});
        else passed++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        drive(0, mk(7'b0110011, 3'b000, 7'b0100000, 32'd15, 32'd5));
        drive(1, mk(7'b0110011, 3'b100, 7'b0000000, 32'd15, 32'd10));
        #1;
        total++;
        if (req_ready !== 2'b01) $display("FAIL simul_first: req_ready=%b expected 01", req_ready);
        else passed++;
        tick();
        req_valid[0] = 1'b0;
        tick();
        total++;
        if ({rsp_valid, rsp_id, rsp_rd} !== {1'b1, 1'b0, 32'd10})
            $display("FAIL simul_rsp0: valid=%b id=%0d rd=%0d expected 1 0 10", rsp_valid, rsp_id, rsp_rd);
        else passed++;
        tick();
        total++;
        if (req_ready !== 2'b10) $display("FAIL simul_second: req_ready=%b expected 10", req_ready);
        else passed++;
        tick();
        req_valid[1] = 1'b0;
        tick();
        total++;
        if ({rsp_valid, rsp_id, rsp_rd} !== {1'b1, 1'b1, 32'd5})
            $display("FAIL simul_rsp1: valid=%b id=%0d rd=%0d expected 1 1 5", rsp_valid, rsp_id, rsp_rd);
        else passed++;
        tick();
    endtask

    task automatic test_fairness();
        int grants;
        int g;
        grants = 0;
        do_reset();
        drive(0, mk(7'b0110011, 3'b000, 7'b0, 32'd1, 32'd1));
        drive(1, mk(7'b0110011, 3'b000, 7'b0, 32'd2, 32'd2));
        for (int c = 0; c < 80 && grants < 6; c++) begin
            #1;
            g = -1;
            if (req_ready == 2'b01) g = 0;
            else if (req_ready == 2'b10) g = 1;
            if (g >= 0) begin
                total++;
                if (g != grants % 2) $display("FAIL fair_order: grant %0d went to %0d expected %0d", grants, g, grants % 2);
                else passed++;
                grants++;
            end
            tick();
        end
        total++;
        if (grants != 6) $display("FAIL fair_count: saw %0d grants expected 6", grants);
        else passed++;
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready = 1'b0;
        drive(0, mk(7'b0110011, 3'b000, 7'b0100000, 32'd7, 32'd7));
        tick();
        req_valid[0] = 1'b0;
        tick();
        drive(1, mk(7'b0110011, 3'b000, 7'b0, 32'd1, 32'd2));
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if ({rsp_valid, rsp_rd, rsp_zero, req_ready, busy} !== {1'b1, 32'd0, 1'b1, 2'b00, 1'b1})
                $display("FAIL bp_hold: cycle %0d valid=%b rd=%0d zero=%b req_ready=%b busy=%b expected 1 0 1 00 1",
                         c, rsp_valid, rsp_rd, rsp_zero, req_ready, busy);
            else passed++;
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        total++;
        if (req_ready !== 2'b10) $display("FAIL bp_next_accept: req_ready=%b expected 10", req_ready);
        else passed++;
        tick();
        req_valid[1] = 1'b0;
        tick();
        total++;
        if ({rsp_valid, rsp_id, rsp_rd} !== {1'b1, 1'b1, 32'd3})
            $display("FAIL bp_rsp1: valid=%b id=%0d rd=%0d expected 1 1 3", rsp_valid, rsp_id, rsp_rd);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        do_reset();
        drive(0, mk(7'b0110011, 3'b000, 7'b0, 32'd1, 32'd2));
        drive(1, mk(7'b0110011, 3'b000, 7'b0, 32'd3, 32'd4));
        tick();
        reset_n = 1'b0;
        #1;
        total++;
        if ({rsp_valid, busy, req_ready} !== 4'b0000 || alu_view !== '0)
            $display("FAIL rstmid_clear: valid/busy/req_ready=%b alu=%h expected 0000 0", {rsp_valid, busy, req_ready}, alu_view);
        else passed++;
        repeat (3) begin
            tick();
            if (rsp_valid || req_ready != 2'b00) seen++;
        end
        total++;
        if (seen != 0) $display("FAIL rstmid_quiet: %0d cycles with activity during reset expected 0", seen);
        else passed++;
        reset_n = 1'b1;
        #1;
        total++;
        if (req_ready !== 2'b01) $display("FAIL rstmid_regrant: req_ready=%b expected 01", req_ready);
        else passed++;
        tick();
        req_valid[0] = 1'b0;
        tick();
        total++;
        if ({rsp_valid, rsp_id, rsp_rd} !== {1'b1, 1'b0, 32'd3})
            $display("FAIL rstmid_rsp: valid=%b id=%0d rd=%0d expected 1 0 3", rsp_valid, rsp_id, rsp_rd);
        else passed++;
    endtask

    task automatic test_three_req();
        int grants;
        int g;
        int last_g;
        int exp_order [4] = '{0, 1, 2, 0};
        grants = 0;
        last_g = 0;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_rs1_3[i*32 +: 32] = 32'(10 * (i + 1));
            req_rs2_3[i*32 +: 32] = 32'(i);
        end
        req_valid3[0] = 1'b1;
        for (int c = 0; c < 60 && grants < 4; c++) begin
            #1;
            if (rsp_valid3) begin
                total++;
                if ({30'd0, rsp_id3} !== 32'(last_g) || rsp_rd3 !== 32'(11 * last_g + 10))
                    $display("FAIL three_rsp: id=%0d rd=%0d expected %0d %0d", rsp_id3, rsp_rd3, last_g, 11 * last_g + 10);
                else passed++;
            end
            g = -1;
            for (int k = 0; k < 3; k++) if (req_ready3[k]) g = k;
            if (g >= 0) begin
                total++;
                if (g != exp_order[grants]) $display("FAIL three_order: grant %0d went to %0d expected %0d", grants, g, exp_order[grants]);
                else passed++;
            end
            tick();
            if (g >= 0) begin
                req_valid3[g] = 1'b0;
                last_g = g;
                grants++;
                if (grants == 1) req_valid3[2:1] = 2'b11;
                if (grants == 2) req_valid3[0] = 1'b1;
            end
        end
        total++;
        if (grants != 4) $display("FAIL three_count: saw %0d grants expected 4", grants);
        else passed++;
    endtask

    // Transaction-level model: one op in flight, response 2 cycles after accept, next accept the
    // cycle after the response is consumed, round-robin among pending requesters.
    task automatic test_random();
        op_t         ops [2];
        bit          pend [2];
        op_t         last;
        int          ptr, g, acc_cyc, free_cyc;
        bit          outst, exp_acc, exp_rv;
        logic [1:0]  exp_rdy;
        logic        exp_id;
        logic [34:0] exp_res;
        do_reset();
        pend = '{0, 0};
        last = '0;
        ptr = 0; outst = 0; acc_cyc = 0; free_cyc = 0; exp_id = 1'b0; exp_res = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    ops[i] = rand_op();
                    pend[i] = 1;
                    drive(i, ops[i]);
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_acc = !outst && cyc >= free_cyc && (pend[0] || pend[1]);
            g = 0;
            if (exp_acc) g = pend[ptr] ? ptr : (ptr + 1) % 2;
            exp_rdy = exp_acc ? (2'b01 << g) : 2'b00;
            exp_rv = outst && cyc >= acc_cyc + 2;
            total++;
            if (req_ready !== exp_rdy) $display("FAIL rand_ready: cycle %0d req_ready=%b expected %b", cyc, req_ready, exp_rdy);
            else passed++;
            total++;
            if (rsp_valid !== exp_rv) $display("FAIL rand_valid: cycle %0d rsp_valid=%b expected %b", cyc, rsp_valid, exp_rv);
            else passed++;
            if (exp_rv) begin
                total++;
                if ({rsp_id, rsp_blt, rsp_bgt, rsp_zero, rsp_rd} !== {exp_id, exp_res})
                    $display("FAIL rand_rsp: cycle %0d got %h expected %h", cyc,
                             {rsp_id, rsp_blt, rsp_bgt, rsp_zero, rsp_rd}, {exp_id, exp_res});
                else passed++;
            end
            total++;
            if (alu_view !== last) $display("FAIL rand_alu_hold: cycle %0d alu=%h expected %h", cyc, alu_view, last);
            else passed++;
            if (exp_acc) begin
                outst = 1; acc_cyc = cyc; exp_id = g[0]; exp_res = alu_fn(ops[g]);
                last = ops[g]; ptr = (g + 1) % 2; pend[g] = 0;
            end
            if (exp_rv && rsp_ready) begin
                outst = 0; free_cyc = cyc + 1;
            end
            tick();
            if (exp_acc) req_valid[g] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_simultaneous();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_three_req();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end

endmodule
